// File: rtl/move_legality_checker.sv
// Maze move-legality checker: computes the target of a one-hot move, bounds-checks
// it, reads the cell code through a fixed-latency memory port and reports the
// outcome. Pickups are consumed on first hit; win/game-over are sticky until new_game.
// All outputs are registered, so each result appears one edge after its state.
module move_legality_checker #(
  parameter int COORD_W   = 5,
  parameter int GRID_W    = 24,
  parameter int GRID_H    = 24,
  parameter int CELL_W    = 3,
  parameter int N_BONUS   = 2,
  parameter int N_PENALTY = 2,
  parameter int IDX_W     = 1,
  parameter int MEM_LAT   = 1
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           new_game,
  input  logic                           abort,
  input  logic                           req_valid,
  input  logic [COORD_W-1:0]             cur_x,
  input  logic [COORD_W-1:0]             cur_y,
  input  logic [3:0]                     dir,
  input  logic                           out_of_moves,
  input  logic                           out_of_time,
  input  logic [N_BONUS*COORD_W-1:0]     bonus_x,
  input  logic [N_BONUS*COORD_W-1:0]     bonus_y,
  input  logic [N_BONUS-1:0]             bonus_en,
  input  logic [N_PENALTY*COORD_W-1:0]   penalty_x,
  input  logic [N_PENALTY*COORD_W-1:0]   penalty_y,
  input  logic [N_PENALTY-1:0]           penalty_en,
  output logic                           mem_rd_en,
  output logic [COORD_W-1:0]             mem_x,
  output logic [COORD_W-1:0]             mem_y,
  input  logic [CELL_W-1:0]              mem_data,
  output logic                           busy,
  output logic                           done,
  output logic                           is_legal,
  output logic [COORD_W-1:0]             new_x,
  output logic [COORD_W-1:0]             new_y,
  output logic                           bonus_hit,
  output logic                           penalty_hit,
  output logic [IDX_W-1:0]               hit_idx,
  output logic                           game_won,
  output logic                           game_over
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CELL_W-1:0] CELL_WALL = '0;
  localparam logic [CELL_W-1:0] CELL_END  = CELL_W'(3);

  typedef enum logic [2:0] {IDLE, BOUNDS, WAIT, EVAL, RESULT, WON, OVER} state_t;
  state_t state, stateNext;

  logic [COORD_W-1:0] latX, latY, tx, ty, resX, resY;
  logic [3:0]         latDir;
  logic [CNT_W-1:0]   waitCnt;
  logic               inBounds, xOk, yOk;
  logic               resLegal, resBonus, resPenalty, termPend;
  logic [IDX_W-1:0]   resIdx, bonusIdx, penaltyIdx;
  logic               bonusHit, penaltyHit, cellWall, cellEnd, evalLegal;
  logic [N_BONUS-1:0]   bonusUsed;
  logic [N_PENALTY-1:0] penaltyUsed;
  logic doneD, legalD, bonusD, penaltyD, memRdD, wonD, overD, busyD;
  logic [IDX_W-1:0]   idxD;
  logic [COORD_W-1:0] newXD, newYD;

  // Target cell and bounds verdict; bounds are judged on the current position so no wrap occurs
  always_comb begin
    tx = latX;
    ty = latY;
    xOk = int'(latX) < GRID_W;
    yOk = int'(latY) < GRID_H;
    inBounds = 1'b0;
    case (latDir)
      4'b0001: begin inBounds = (latX != '0) && (int'(latX) <= GRID_W) && yOk; tx = latX - COORD_W'(1); end
      4'b0010: begin inBounds = (int'(latX) < GRID_W - 1) && yOk;               tx = latX + COORD_W'(1); end
      4'b0100: begin inBounds = (latY != '0) && (int'(latY) <= GRID_H) && xOk; ty = latY - COORD_W'(1); end
      4'b1000: begin inBounds = (int'(latY) < GRID_H - 1) && xOk;               ty = latY + COORD_W'(1); end
      default: inBounds = 1'b0;
    endcase
  end

  // Pickup match against the registered target; descending loop lets the lowest index win
  always_comb begin
    bonusHit = 1'b0;
    bonusIdx = '0;
    for (int i = N_BONUS - 1; i >= 0; i--) begin
      if (bonus_en[i] && !bonusUsed[i] &&
          bonus_x[i*COORD_W +: COORD_W] == mem_x && bonus_y[i*COORD_W +: COORD_W] == mem_y) begin
        bonusHit = 1'b1;
        bonusIdx = IDX_W'(i);
      end
    end
    penaltyHit = 1'b0;
    penaltyIdx = '0;
    for (int i = N_PENALTY - 1; i >= 0; i--) begin
      if (penalty_en[i] && !penaltyUsed[i] &&
          penalty_x[i*COORD_W +: COORD_W] == mem_x && penalty_y[i*COORD_W +: COORD_W] == mem_y) begin
        penaltyHit = 1'b1;
        penaltyIdx = IDX_W'(i);
      end
    end
    cellWall  = (mem_data == CELL_WALL);
    cellEnd   = (mem_data == CELL_END);
    evalLegal = bonusHit || penaltyHit || !cellWall;
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic: new_game beats abort; abort cannot leave a terminal state
  always_comb begin
    stateNext = state;
    if (new_game) begin
      stateNext = IDLE;
    end else if (abort && state != WON && state != OVER) begin
      stateNext = OVER;
    end else begin
      case (state)
        IDLE:    if (req_valid) stateNext = BOUNDS;
        BOUNDS:  if (out_of_moves || out_of_time) stateNext = OVER;
                 else if (!inBounds)              stateNext = RESULT;
                 else                             stateNext = WAIT;
        WAIT:    if (waitCnt == CNT_W'(1)) stateNext = EVAL;
        EVAL:    stateNext = (!bonusHit && !penaltyHit && cellEnd) ? WON : RESULT;
        RESULT:  stateNext = IDLE;
        default: stateNext = state;
      endcase
    end
  end

  // Output values for the next edge, derived from the current state
  always_comb begin
    doneD    = 1'b0;
    legalD   = 1'b0;
    bonusD   = 1'b0;
    penaltyD = 1'b0;
    idxD     = '0;
    newXD    = new_x;
    newYD    = new_y;
    memRdD   = 1'b0;
    wonD     = game_won;
    overD    = game_over;
    busyD    = (stateNext != IDLE);
    if (new_game) begin
      wonD  = 1'b0;
      overD = 1'b0;
    end else begin
      case (state)
        BOUNDS: memRdD = (stateNext == WAIT);
        RESULT: if (!abort) begin
                  doneD = 1'b1; legalD = resLegal; bonusD = resBonus; penaltyD = resPenalty;
                  idxD = resIdx; newXD = resX; newYD = resY;
                end
        WON:    if (termPend) begin
                  doneD = 1'b1; legalD = 1'b1; newXD = resX; newYD = resY; wonD = 1'b1;
                end
        OVER:   if (termPend) begin
                  doneD = 1'b1; overD = 1'b1;
                end
        default: ;
      endcase
    end
  end

  // Request latch, wait counter, result capture, consumed masks and output registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      latX <= '0; latY <= '0; latDir <= '0; waitCnt <= '0;
      resX <= '0; resY <= '0; resLegal <= 1'b0; resBonus <= 1'b0; resPenalty <= 1'b0;
      resIdx <= '0; termPend <= 1'b0; bonusUsed <= '0; penaltyUsed <= '0;
      mem_rd_en <= 1'b0; mem_x <= '0; mem_y <= '0; busy <= 1'b0; done <= 1'b0;
      is_legal <= 1'b0; new_x <= '0; new_y <= '0; bonus_hit <= 1'b0; penalty_hit <= 1'b0;
      hit_idx <= '0; game_won <= 1'b0; game_over <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        latX <= cur_x; latY <= cur_y; latDir <= dir;
      end
      termPend <= (stateNext != state) && (stateNext == WON || stateNext == OVER);
      if (state == BOUNDS && stateNext == WAIT) begin
        mem_x <= tx; mem_y <= ty; waitCnt <= CNT_W'(MEM_LAT);
      end
      if (state == WAIT) waitCnt <= waitCnt - CNT_W'(1);
      if (state == BOUNDS && stateNext == RESULT) begin
        resLegal <= 1'b0; resBonus <= 1'b0; resPenalty <= 1'b0; resIdx <= '0;
        resX <= latX; resY <= latY;
      end
      if (state == EVAL && (stateNext == RESULT || stateNext == WON)) begin
        resLegal   <= evalLegal;
        resBonus   <= bonusHit;
        resPenalty <= !bonusHit && penaltyHit;
        resIdx     <= bonusHit ? bonusIdx : (penaltyHit ? penaltyIdx : '0);
        resX       <= evalLegal ? mem_x : latX;
        resY       <= evalLegal ? mem_y : latY;
        if (bonusHit)        bonusUsed[bonusIdx]     <= 1'b1;
        else if (penaltyHit) penaltyUsed[penaltyIdx] <= 1'b1;
      end
      if (new_game) begin
        bonusUsed <= '0; penaltyUsed <= '0;
      end
      mem_rd_en <= memRdD; busy <= busyD; done <= doneD; is_legal <= legalD;
      new_x <= newXD; new_y <= newYD; bonus_hit <= bonusD; penalty_hit <= penaltyD;
      hit_idx <= idxD; game_won <= wonD; game_over <= overD;
    end
  end

endmodule

// File: tb/tb_move_legality_checker.sv
// Directed bench for move_legality_checker: one instance with MEM_LAT=1 and one
// with MEM_LAT=4 sharing most inputs; each has its own request and abort.
module tb_move_legality_checker;
  localparam int CW = 5;

  logic clock = 1'b0;
  logic resetn, new_game, abort, abort4, req_valid, req4;
  logic [CW-1:0] cur_x, cur_y;
  logic [3:0] dir;
  logic out_of_moves, out_of_time;
  logic [2*CW-1:0] bonus_x, bonus_y, penalty_x, penalty_y;
  logic [1:0] bonus_en, penalty_en;
  logic [2:0] mem_data;

  logic mem_rd_en, busy, done, is_legal, bonus_hit, penalty_hit, game_won, game_over;
  logic [CW-1:0] mem_x, mem_y, new_x, new_y;
  logic [0:0] hit_idx;
  logic mem_rd_en4, busy4, done4, is_legal4, bonus_hit4, penalty_hit4, game_won4, game_over4;
  logic [CW-1:0] mem_x4, mem_y4, new_x4, new_y4;
  logic [0:0] hit_idx4;

  int testCnt = 0;
  int failCnt = 0;

  always #5 clock = ~clock;

  move_legality_checker #(.MEM_LAT(1)) dut (
    .clock(clock), .resetn(resetn), .new_game(new_game), .abort(abort), .req_valid(req_valid),
    .cur_x(cur_x), .cur_y(cur_y), .dir(dir), .out_of_moves(out_of_moves), .out_of_time(out_of_time),
    .bonus_x(bonus_x), .bonus_y(bonus_y), .bonus_en(bonus_en),
    .penalty_x(penalty_x), .penalty_y(penalty_y), .penalty_en(penalty_en),
    .mem_rd_en(mem_rd_en), .mem_x(mem_x), .mem_y(mem_y), .mem_data(mem_data),
    .busy(busy), .done(done), .is_legal(is_legal), .new_x(new_x), .new_y(new_y),
    .bonus_hit(bonus_hit), .penalty_hit(penalty_hit), .hit_idx(hit_idx),
    .game_won(game_won), .game_over(game_over));

  move_legality_checker #(.MEM_LAT(4)) dut4 (
    .clock(clock), .resetn(resetn), .new_game(new_game), .abort(abort4), .req_valid(req4),
    .cur_x(cur_x), .cur_y(cur_y), .dir(dir), .out_of_moves(out_of_moves), .out_of_time(out_of_time),
    .bonus_x(bonus_x), .bonus_y(bonus_y), .bonus_en(bonus_en),
    .penalty_x(penalty_x), .penalty_y(penalty_y), .penalty_en(penalty_en),
    .mem_rd_en(mem_rd_en4), .mem_x(mem_x4), .mem_y(mem_y4), .mem_data(mem_data),
    .busy(busy4), .done(done4), .is_legal(is_legal4), .new_x(new_x4), .new_y(new_y4),
    .bonus_hit(bonus_hit4), .penalty_hit(penalty_hit4), .hit_idx(hit_idx4),
    .game_won(game_won4), .game_over(game_over4));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (edge k); returns #1 after edge k
  task automatic sendReq(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [3:0] d,
                         input logic toFast);
    cur_x = x; cur_y = y; dir = d;
    if (toFast) req_valid = 1'b1; else req4 = 1'b1;
    tick();
    req_valid = 1'b0; req4 = 1'b0;
  endtask

  // Illegal move without memory access: done/is_legal=0 at k+2, no read strobe
  task automatic illegalMove(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                             input logic [3:0] d);
    sendReq(x, y, d, 1'b1);
    tick();
    chk({tag, "_rd_k1"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_done_k1"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done_k2"}, 32'(done), 32'd1);
    chk({tag, "_legal_k2"}, 32'(is_legal), 32'd0);
    chk({tag, "_rd_k2"}, 32'(mem_rd_en), 32'd0);
  endtask

  // Legal-path move on the MEM_LAT=1 instance: checks result at k+4
  task automatic fastMove(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                          input logic [3:0] d, input logic expLegal, input logic expBonus,
                          input logic expPenalty, input logic [0:0] expIdx);
    sendReq(x, y, d, 1'b1);
    tick(); tick(); tick();
    chk({tag, "_done_k3"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_legal"}, 32'(is_legal), 32'(expLegal));
    chk({tag, "_bonus"}, 32'(bonus_hit), 32'(expBonus));
    chk({tag, "_penalty"}, 32'(penalty_hit), 32'(expPenalty));
    chk({tag, "_idx"}, 32'(hit_idx), 32'(expIdx));
  endtask

  initial begin
    resetn = 1'b0; new_game = 1'b0; abort = 1'b0; abort4 = 1'b0; req_valid = 1'b0; req4 = 1'b0;
    cur_x = '0; cur_y = '0; dir = '0; out_of_moves = 1'b0; out_of_time = 1'b0;
    bonus_x = '0; bonus_y = '0; bonus_en = '0; penalty_x = '0; penalty_y = '0; penalty_en = '0;
    mem_data = 3'd1;
    tick(); tick();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(mem_rd_en), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    resetn = 1'b1;
    tick();

    // MEM_LAT=4 latency: read strobe at k+1, done at k+7 only
    sendReq(5'd5, 5'd5, 4'b0010, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk($sformatf("lat4_rd_%0d", n), 32'(mem_rd_en4), 32'(n == 1));
      chk($sformatf("lat4_done_%0d", n), 32'(done4), 32'(n == 7));
    end
    chk("lat4_legal", 32'(is_legal4), 32'd1);
    chk("lat4_newx", 32'(new_x4), 32'd6);
    tick();

    // Abort during WAIT on MEM_LAT=4: only the OVER pulse, with is_legal=0
    sendReq(5'd5, 5'd5, 4'b0010, 1'b0);
    tick(); tick();
    chk("ab4_busy", 32'(busy4), 32'd1);
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    chk("ab4_done_early", 32'(done4), 32'd0);
    tick();
    chk("ab4_done", 32'(done4), 32'd1);
    chk("ab4_legal", 32'(is_legal4), 32'd0);
    chk("ab4_over", 32'(game_over4), 32'd1);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("ab4_nodone_%0d", n), 32'(done4), 32'd0);
    end
    chk("ab4_over_sticky", 32'(game_over4), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("ab4_rst_over", 32'(game_over4), 32'd0);
    chk("ab4_rst_busy", 32'(busy4), 32'd0);

    // Basic legal move (5,5) right on MEM_LAT=1
    sendReq(5'd5, 5'd5, 4'b0010, 1'b1);
    chk("mv_busy", 32'(busy), 32'd1);
    tick();
    chk("mv_rd", 32'(mem_rd_en), 32'd1);
    chk("mv_memx", 32'(mem_x), 32'd6);
    chk("mv_memy", 32'(mem_y), 32'd5);
    tick();
    chk("mv_rd_once", 32'(mem_rd_en), 32'd0);
    tick();
    chk("mv_done_k3", 32'(done), 32'd0);
    tick();
    chk("mv_done", 32'(done), 32'd1);
    chk("mv_legal", 32'(is_legal), 32'd1);
    chk("mv_newx", 32'(new_x), 32'd6);
    chk("mv_newy", 32'(new_y), 32'd5);
    tick();
    chk("mv_done_once", 32'(done), 32'd0);
    chk("mv_idle", 32'(busy), 32'd0);

    illegalMove("oob_left", 5'd0, 5'd3, 4'b0001);
    illegalMove("oob_right", 5'd23, 5'd3, 4'b0010);
    illegalMove("multihot", 5'd5, 5'd5, 4'b0011);
    illegalMove("nodir", 5'd5, 5'd5, 4'b0000);

    // Edge of grid but in range: (22,3) right lands on (23,3)
    fastMove("edge_ok", 5'd22, 5'd3, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("edge_newx", 32'(new_x), 32'd23);

    // Pickups: bonus 0 disabled, bonus 1 enabled, both at (6,5); penalty 0 at (7,5)
    bonus_x = {5'd6, 5'd6}; bonus_y = {5'd5, 5'd5}; bonus_en = 2'b10;
    penalty_x = {5'd0, 5'd7}; penalty_y = {5'd0, 5'd5}; penalty_en = 2'b01;
    mem_data = 3'd0;
    fastMove("bonus1", 5'd5, 5'd5, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);
    fastMove("bonus_used", 5'd5, 5'd5, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_data = 3'd1;
    fastMove("penalty0", 5'd6, 5'd5, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
    fastMove("penalty_used", 5'd6, 5'd5, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);

    // END cell wins and is sticky; requests are then ignored
    mem_data = 3'd3;
    fastMove("win", 5'd5, 5'd5, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("win_flag", 32'(game_won), 32'd1);
    tick();
    chk("win_done_once", 32'(done), 32'd0);
    sendReq(5'd5, 5'd5, 4'b0010, 1'b1);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("win_ignore_%0d", n), 32'(done), 32'd0);
    end
    chk("win_sticky", 32'(game_won), 32'd1);
    chk("win_busy", 32'(busy), 32'd1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng_won", 32'(game_won), 32'd0);
    chk("ng_busy", 32'(busy), 32'd0);

    // new_game cleared the consumed mask: bonus 1 hits again on a WALL cell
    mem_data = 3'd0;
    fastMove("bonus_again", 5'd5, 5'd5, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);

    // Abort during WAIT on MEM_LAT=1, then a one-cycle reset
    mem_data = 3'd1;
    sendReq(5'd10, 5'd10, 4'b0001, 1'b1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_done_early", 32'(done), 32'd0);
    tick();
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_legal", 32'(is_legal), 32'd0);
    chk("ab_over", 32'(game_over), 32'd1);
    tick();
    chk("ab_done_once", 32'(done), 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst2_over", 32'(game_over), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_memx", 32'(mem_x), 32'd0);
    chk("rst2_newx", 32'(new_x), 32'd0);

    // out_of_time beats an out-of-bounds move
    out_of_time = 1'b1;
    sendReq(5'd0, 5'd3, 4'b0001, 1'b1);
    tick();
    chk("oot_done_k1", 32'(done), 32'd0);
    tick();
    chk("oot_done", 32'(done), 32'd1);
    chk("oot_legal", 32'(is_legal), 32'd0);
    chk("oot_over", 32'(game_over), 32'd1);
    out_of_time = 1'b0;

    // abort together with new_game returns to IDLE
    abort = 1'b1; new_game = 1'b1;
    tick();
    abort = 1'b0; new_game = 1'b0;
    chk("abng_over", 32'(game_over), 32'd0);
    chk("abng_busy", 32'(busy), 32'd0);
    tick();
    chk("abng_done", 32'(done), 32'd0);
    chk("abng_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end
endmodule

// File: doc/move_legality_checker.md
Name: move_legality_checker

Overview:
- Parametrised successor to the maze move-legality FSM.
- Takes a move request (current position plus one-hot direction) and computes the target cell. It then bounds-checks the target, reads the cell code from maze memory with a configurable read latency, and reports the result: legal/illegal, bonus, penalty, win or game over.
- Generalisations: grid size, number of bonus and penalty tiles, and memory latency are parameters.
- New behaviour: pickups are consumed on first hit, and win/game-over are sticky until `new_game`.

Parameters:
- `COORD_W`, 5, width of x/y coordinates.
- `GRID_W`, 24, number of columns; legal x is 0..`GRID_W`-1.
- `GRID_H`, 24, number of rows; legal y is 0..`GRID_H`-1.
- `CELL_W`, 3, width of the maze cell code.
- `N_BONUS`, 2, number of +score tiles.
- `N_PENALTY`, 2, number of -score tiles.
- `IDX_W`, 1, width of the pickup index; must satisfy 2^`IDX_W` >= max(`N_BONUS`, `N_PENALTY`).
- `MEM_LAT`, 1, maze memory read latency in cycles; must be >= 1.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  synchronous active-low reset.
- `new_game`  in  1  pulse: return to IDLE, clear consumed mask and sticky flags.
- `abort`  in  1  force GAME_OVER from any non-terminal state.
- `req_valid`  in  1  move request; sampled only in IDLE.
- `cur_x`, `cur_y`  in  `COORD_W` each  current player position, held stable while busy.
- `dir`  in  4  one-hot {down, up, right, left}; zero or multi-hot makes the move illegal.
- `out_of_moves`, `out_of_time`  in  1 each  game-end conditions.
- `bonus_x`, `bonus_y`  in  `N_BONUS`*`COORD_W` each  packed tile coordinates; entry i at [i*`COORD_W` +: `COORD_W`].
- `bonus_en`  in  `N_BONUS`  per-tile enable.
- `penalty_x`, `penalty_y`  in  `N_PENALTY`*`COORD_W` each  packed tile coordinates.
- `penalty_en`  in  `N_PENALTY`  per-tile enable.
- `mem_rd_en`  out  1  one-cycle memory read strobe.
- `mem_x`, `mem_y`  out  `COORD_W` each  target cell address.
- `mem_data`  in  `CELL_W`  cell code; valid `MEM_LAT` cycles after `mem_rd_en` and held until the next read.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle result strobe.
- `is_legal`  out  1  move legal; qualified by `done`.
- `new_x`, `new_y`  out  `COORD_W` each  target position, valid with `done`.
- `bonus_hit`, `penalty_hit`  out  1 each  pickup taken; pulse with `done`.
- `hit_idx`  out  `IDX_W`  index of the pickup taken.
- `game_won`, `game_over`  out  1 each  sticky terminal flags.

Behaviour:
- **Reset.** `resetn`=0 at a clock edge forces state IDLE, consumed masks to 0, and every output to 0.
- **Cell codes.** WALL=0, FREE=1, START=2, END=3. Any other code is treated as FREE.
- **States.** IDLE, BOUNDS, WAIT, EVAL, RESULT, WON, OVER.
- **IDLE.** If `req_valid`=1, latch `cur_x`, `cur_y`, `dir` and go to BOUNDS.
- **BOUNDS.**
  - If `out_of_moves` or `out_of_time` is set: go to OVER. This has priority.
  - Else if `dir` is not one-hot, or the target would be x<0, x>=`GRID_W`, y<0 or y>=`GRID_H`: go to RESULT with `is_legal`=0.
  - Bounds are compared before arithmetic, so no wrap-around occurs.
  - Else: assert `mem_rd_en` for this cycle only, drive `mem_x`/`mem_y` with the target, load the wait counter with `MEM_LAT`, go to WAIT.
- **WAIT.** Decrement the counter; go to EVAL when it reaches 1.
- **EVAL.** Sample `mem_data` and apply the first match in this order:
  - (a) Enabled, unconsumed bonus i equals the target (lowest i wins): legal, `bonus_hit`=1, `hit_idx`=i, set consumed bit i. This applies even on a WALL cell.
  - (b) Same rule for penalty tiles: legal, `penalty_hit`=1.
  - (c) WALL: `is_legal`=0.
  - (d) END: legal, go to WON.
  - (e) Otherwise legal.
  - A consumed tile is ignored afterwards; the cell is then judged by its code alone.
- **RESULT.** `done`=1 for exactly one cycle together with `is_legal`, `new_x`/`new_y`, and any hit pulse. Then go to IDLE.
- **WON.** Emit one `done` pulse with `is_legal`=1, set `game_won`, stay in WON.
- **OVER.** Emit one `done` pulse with `is_legal`=0, set `game_over`, stay in OVER.
- **Leaving terminal states.** Only `resetn`=0 or `new_game`=1 exits WON or OVER.
- **Latency**, with the request sampled at edge k:
  - out-of-bounds or game-end: result at cycle k+2;
  - legal path: `done` at cycle k+3+`MEM_LAT`.
- **`abort`.** Goes to OVER from IDLE, BOUNDS, WAIT, EVAL or RESULT. Any in-flight result is dropped: no normal `done`, and consumed bits are not updated.
- **`new_game` in any state.** Goes to IDLE next edge, clears `game_won`/`game_over`/consumed masks, drops any in-flight request. `new_game` has priority over `abort`; `resetn` has priority over both.
- **Unused requests.** `req_valid` outside IDLE is ignored; there is no queueing.

Test Plan:
- `cur`=(5,5), `dir`=right, `mem_data`=1, `MEM_LAT`=1 -> `mem_rd_en` at k+1 with `mem_x`/`mem_y`=(6,5); `done`,`is_legal`=1 at k+4; `new_x`/`new_y`=(6,5).
- `cur`=(0,3) with left; `cur`=(23,3) with right; `dir`=4'b0011 -> each gives `done` at k+2, `is_legal`=0, no `mem_rd_en`.
- Bonus 1 at (6,5) enabled, `mem_data`=0 -> `bonus_hit`=1, `hit_idx`=1, `is_legal`=1. Repeat the same move -> judged as WALL, `is_legal`=0, no hit.
- Target (6,5) with `mem_data`=3 -> `done`+`is_legal` once, then `game_won` stays high. A further `req_valid` gives no `done`. A `new_game` pulse -> IDLE, `game_won`=0.
- `abort` asserted during WAIT (`MEM_LAT`=4) -> no normal result; OVER `done` pulse with `is_legal`=0 and `game_over`=1. `resetn`=0 for one cycle -> all outputs 0.
- `out_of_time`=1 with an out-of-bounds move -> OVER, not an illegal RESULT. `abort` and `new_game` in the same cycle -> IDLE.
